// File: rtl/controle_contagem_regressiva.sv
// Round countdown timer controller.
// Sequences an external 4-bit down counter: clears it while idle, loads the
// captured limit, then strobes one count step every TICK_DIV clocks until the
// counter's rco reports zero. Supports pause (partial-step time is kept) and
// cancel, and reports expiry with a one-cycle timeout pulse.
module controle_contagem_regressiva #(
  parameter int TICK_DIV = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       pausar,
  input  logic       cancelar,
  input  logic [3:0] limite,
  input  logic       rco,
  output logic       zera_n,
  output logic       carrega_n,
  output logic       conta_t,
  output logic       conta_p,
  output logic [5:0] valor_carga,
  output logic       ativo,
  output logic       pausado,
  output logic       timeout,
  output logic [2:0] db_estado
);

  // Prescaler needs at least one bit even when every clock is a step.
  localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    INICIAL  = 3'b000,
    PREPARA  = 3'b001,
    CONTA    = 3'b010,
    PAUSA    = 3'b011,
    EXPIRADO = 3'b100
  } estado_t;

  estado_t              estado;
  estado_t              estado_prox;
  logic [PRESC_W-1:0]   presc;
  logic [PRESC_W-1:0]   presc_prox;
  logic                 passo_livre;
  logic                 fim_passo;

  // Counting advances only in CONTA with nothing holding it back; rco blocks
  // the strobe so the counter can never wrap below zero.
  assign passo_livre = (estado == CONTA) && !rco && !pausar && !cancelar;
  assign fim_passo   = (presc == PRESC_MAX);
  assign conta_p     = passo_livre && fim_passo;
  assign db_estado   = estado;

  // Next-state selection; in CONTA cancel beats expiry, expiry beats pause.
  always_comb begin
    estado_prox = INICIAL;
    case (estado)
      INICIAL:  estado_prox = iniciar ? PREPARA : INICIAL;
      PREPARA:  estado_prox = CONTA;
      CONTA: begin
        if (cancelar)      estado_prox = INICIAL;
        else if (rco)      estado_prox = EXPIRADO;
        else if (pausar)   estado_prox = PAUSA;
        else               estado_prox = CONTA;
      end
      PAUSA: begin
        if (cancelar)      estado_prox = INICIAL;
        else if (!pausar)  estado_prox = CONTA;
        else               estado_prox = PAUSA;
      end
      EXPIRADO: estado_prox = INICIAL;
      default:  estado_prox = INICIAL;
    endcase
  end

  // Prescaler: zeroed before a countdown, frozen while paused so no
  // partial-step time is lost, wraps on the strobe cycle.
  always_comb begin
    presc_prox = presc;
    case (estado)
      INICIAL, PREPARA: presc_prox = '0;
      CONTA: begin
        if (passo_livre) begin
          presc_prox = fim_passo ? '0 : presc + PRESC_W'(1);
        end
      end
      default: presc_prox = presc;
    endcase
  end

  // State, prescaler, captured limit and Moore outputs registered together;
  // outputs are decoded from the next state so they line up with the state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado      <= INICIAL;
      presc       <= '0;
      valor_carga <= '0;
      zera_n      <= 1'b0;
      carrega_n   <= 1'b1;
      conta_t     <= 1'b0;
      ativo       <= 1'b0;
      pausado     <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      estado <= estado_prox;
      presc  <= presc_prox;
      if ((estado == INICIAL) && iniciar) begin
        valor_carga <= {2'b00, limite};
      end
      zera_n    <= (estado_prox != INICIAL);
      carrega_n <= (estado_prox != PREPARA);
      conta_t   <= (estado_prox == CONTA);
      ativo     <= (estado_prox == PREPARA) || (estado_prox == CONTA) ||
                   (estado_prox == PAUSA);
      pausado   <= (estado_prox == PAUSA);
      timeout   <= (estado_prox == EXPIRADO);
    end
  end

endmodule
